// File: rtl/intra_sad_accum_pkg.sv
// Shared types, sizing helpers and FSM encoding for the intra SAD accumulator.
package intra_sad_accum_pkg;

  typedef logic [7:0] pixel_t;
  typedef logic [7:0] sad_t;

  // Accumulator width for the default 8x8 macroblock.
  localparam int ACC_W = 8 + $clog2(8 * 8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int num_modes(input int mb_l);
    return (mb_l == 4) ? 8 : 3;
  endfunction

  function automatic pixel_t abs_diff(input pixel_t a, input pixel_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/intra_sad_accum_sad_row.sv
// One prediction mode: per-pixel |orig - pred| registered in S1, then summed.
module intra_sad_accum_sad_row
  import intra_sad_accum_pkg::*;
#(
  parameter int W     = 8,
  parameter int ROW_W = 8 + $clog2(W)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [W*8-1:0]   orig_i,
  input  logic [W*8-1:0]   pred_i,
  output logic [ROW_W-1:0] row_sum_o
);

  pixel_t [W-1:0]   diff_d, diff_q;
  logic [ROW_W-1:0] sum;

  always_comb begin
    diff_d = '0;
    for (int p = 0; p < W; p++) begin
      diff_d[p] = abs_diff(orig_i[p*8 +: 8], pred_i[p*8 +: 8]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      diff_q <= '0;
    end else if (en_i) begin
      diff_q <= diff_d;
    end
  end

  // Sum is formed from the registered diffs; the accumulator adds it one cycle later.
  always_comb begin
    sum = '0;
    for (int p = 0; p < W; p++) begin
      sum = sum + ROW_W'(diff_q[p]);
    end
  end

  assign row_sum_o = sum;

endmodule

// File: rtl/intra_sad_accum.sv
// Per-mode macroblock SAD accumulator: row handshake, 2-stage pipe, rounded mean output.
module intra_sad_accum
  import intra_sad_accum_pkg::*;
#(
  parameter int MB_SIZE_L = 8,
  parameter int MB_SIZE_W = 8,
  parameter int NUM_MODES = num_modes(MB_SIZE_L)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [MB_SIZE_W*8-1:0]           orig_row_i,
  input  logic [NUM_MODES*MB_SIZE_W*8-1:0] pred_rows_i,
  output logic [NUM_MODES*8-1:0]           sads_o,
  output logic                             sads_valid_o,
  output logic                             busy_o
);

  localparam int NPIX  = MB_SIZE_L * MB_SIZE_W;
  localparam int S     = $clog2(NPIX);
  localparam int ACCW  = 8 + S;
  localparam int ROW_W = 8 + $clog2(MB_SIZE_W);
  localparam int CNT_W = $clog2(MB_SIZE_L + 1);
  localparam logic [ACCW:0] RND_HALF = {{ACCW{1'b0}}, 1'b1} << (S - 1);
  localparam logic [ACCW:0] SAT_MAX  = {{(ACCW-7){1'b0}}, 8'hFF};

  generate
    if ((NPIX & (NPIX - 1)) != 0) begin : g_npix_chk
      $error("MB_SIZE_L*MB_SIZE_W must be a power of two");
    end
  endgenerate

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                row_cnt_q, row_cnt_d;
  logic                            drain_q, drain_d;
  logic                            vld_s1_q;
  logic [NUM_MODES-1:0][ACCW-1:0]  acc_q, acc_d;
  logic [NUM_MODES-1:0][ROW_W-1:0] row_sum;
  logic [NUM_MODES-1:0][ACCW:0]    rnd;
  sad_t [NUM_MODES-1:0]            sads_q, sads_d;
  logic                            accept;
  logic                            clr_acc;
  logic                            load_sads;

  assign accept = in_valid_i && in_ready_o;

  generate
    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
      intra_sad_accum_sad_row #(
        .W     (MB_SIZE_W),
        .ROW_W (ROW_W)
      ) u_row (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .en_i      (accept),
        .orig_i    (orig_row_i),
        .pred_i    (pred_rows_i[m*MB_SIZE_W*8 +: MB_SIZE_W*8]),
        .row_sum_o (row_sum[m])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    drain_d      = drain_q;
    in_ready_o   = 1'b0;
    sads_valid_o = 1'b0;
    busy_o       = 1'b1;
    clr_acc      = 1'b0;
    load_sads    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        drain_d    = 1'b0;
        if (in_valid_i) begin
          clr_acc   = 1'b1;
          row_cnt_d = CNT_W'(1);
          state_d   = (MB_SIZE_L == 1) ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          row_cnt_d = row_cnt_q + CNT_W'(1);
          if (row_cnt_q == CNT_W'(MB_SIZE_L - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Second drain cycle: last row is in acc, so capture the normalized result.
        drain_d = 1'b1;
        if (drain_q) begin
          load_sads = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        sads_valid_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_acc) begin
      acc_d = '0;
    end else if (vld_s1_q) begin
      for (int m = 0; m < NUM_MODES; m++) begin
        acc_d[m] = acc_q[m] + ACCW'(row_sum[m]);
      end
    end
  end

  always_comb begin
    rnd    = '0;
    sads_d = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      rnd[m]    = ({1'b0, acc_q[m]} + RND_HALF) >> S;
      sads_d[m] = (rnd[m] > SAT_MAX) ? 8'hFF : rnd[m][7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      drain_q   <= 1'b0;
      vld_s1_q  <= 1'b0;
      acc_q     <= '0;
      sads_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      drain_q   <= drain_d;
      vld_s1_q  <= accept;
      acc_q     <= acc_d;
      if (load_sads) begin
        sads_q <= sads_d;
      end
    end
  end

  assign sads_o = sads_q;

endmodule

// File: tb/tb_intra_sad_accum.sv
// Table-driven and randomized checks of intra_sad_accum against a plain arithmetic model.
module tb_intra_sad_accum;
  localparam int L = 8;
  localparam int W = 8;
  localparam int M = 3;

  typedef int iarr_t[M];
  typedef struct {
    int o; int p0; int p1; int p2; bit alt;
    int sa; int sl;
    int e0; int e1; int e2;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [W*8-1:0] orig_row_i;
  logic [M*W*8-1:0] pred_rows_i;
  logic [M*8-1:0] sads_o;
  logic           sads_valid_o;
  logic           busy_o;

  always #5 clk = ~clk;

  intra_sad_accum #(.MB_SIZE_L(L), .MB_SIZE_W(W), .NUM_MODES(M)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .orig_row_i   (orig_row_i),
    .pred_rows_i  (pred_rows_i),
    .sads_o       (sads_o),
    .sads_valid_o (sads_valid_o),
    .busy_o       (busy_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int             pq_cyc[$];
  logic [M*8-1:0] pq_sads[$];
  always @(negedge clk) begin
    if (sads_valid_o) begin
      pq_cyc.push_back(cyc);
      pq_sads.push_back(sads_o);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bounded wait expired", nm);
  endtask

  logic [7:0] b_orig[L][W];
  logic [7:0] b_pred[M][L][W];
  int first_cyc, last_cyc, ready_waits;

  task automatic fill_const(input int o, input int p0, input int p1, input int p2, input bit alt);
    for (int r = 0; r < L; r++)
      for (int p = 0; p < W; p++) begin
        b_orig[r][p]    = 8'(o);
        b_pred[0][r][p] = alt ? 8'(o + ((p % 2 == 0) ? 1 : 0)) : 8'(p0);
        b_pred[1][r][p] = 8'(p1);
        b_pred[2][r][p] = 8'(p2);
      end
  endtask

  // Rounded mean of |orig - pred| over the block, clipped to 8 bits.
  function automatic iarr_t model();
    iarr_t e;
    for (int m = 0; m < M; m++) begin
      int sum = 0;
      for (int r = 0; r < L; r++)
        for (int p = 0; p < W; p++) begin
          int d = int'(b_orig[r][p]) - int'(b_pred[m][r][p]);
          sum += (d < 0) ? -d : d;
        end
      e[m] = (sum + (L * W) / 2) / (L * W);
      if (e[m] > 255) e[m] = 255;
    end
    return e;
  endfunction

  task automatic apply_row(input int r);
    for (int p = 0; p < W; p++) begin
      orig_row_i[p*8 +: 8] = b_orig[r][p];
      for (int m = 0; m < M; m++) pred_rows_i[(m*W+p)*8 +: 8] = b_pred[m][r][p];
    end
  endtask

  task automatic drive_rows(input int nrows, input int stall_after, input int stall_len, input bit hold);
    for (int r = 0; r < nrows; r++) begin
      bit ok = 1'b0;
      int waits = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
        @(negedge clk);
        apply_row(r);
        in_valid_i = 1'b1;
        if (in_ready_o) ok = 1'b1;
        else waits++;
      end
      if (!ok) begin
        fail_now($sformatf("row%0d accept", r));
        in_valid_i = 1'b0;
        return;
      end
      if (r == 0) begin
        first_cyc   = cyc;
        ready_waits = waits;
      end
      last_cyc = cyc;
      if (r + 1 == stall_after) repeat (stall_len) begin
        @(negedge clk);
        in_valid_i = 1'b0;
      end
    end
    if (!hold) begin
      @(negedge clk);
      in_valid_i = 1'b0;
    end
  endtask

  task automatic check_block(input string nm, input iarr_t exp, input int f_cyc, input int l_cyc, input int stall);
    int g = 0;
    int pc;
    logic [M*8-1:0] ps;
    while (pq_cyc.size() == 0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    if (pq_cyc.size() == 0) begin
      fail_now({nm, " pulse"});
      return;
    end
    pc = pq_cyc.pop_front();
    ps = pq_sads.pop_front();
    chk({nm, " latency"}, pc - l_cyc, 3);
    chk({nm, " span"}, pc - f_cyc, L - 1 + 3 + stall);
    for (int m = 0; m < M; m++) chk($sformatf("%s sad%0d", nm, m), ps[m*8 +: 8], exp[m]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[6];
    iarr_t e;
    int fa, la, fb, lb, wb;

    tbl[0] = '{100, 100, 110,  90, 1'b0, 0, 0,   0,  10,  10};
    tbl[1] = '{255,   0, 255, 128, 1'b0, 0, 0, 255,   0, 127};
    tbl[2] = '{100,   0, 100,  50, 1'b1, 0, 0,   1,   0,  50};
    tbl[3] = '{100, 100, 110,  90, 1'b0, 3, 5,   0,  10,  10};
    tbl[4] = '{ 20,  27,  13,  27, 1'b0, 0, 0,   7,   7,   7};
    tbl[5] = '{  0, 255,   1,   3, 1'b0, 6, 2, 255,   1,   3};

    reset_i     = 1'b1;
    in_valid_i  = 1'b0;
    orig_row_i  = '0;
    pred_rows_i = '0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    chk("reset in_ready", in_ready_o, 1);
    chk("reset busy", busy_o, 0);
    chk("reset sads_valid", sads_valid_o, 0);
    chk("reset sads", sads_o, 0);

    for (int i = 0; i < 6; i++) begin
      fill_const(tbl[i].o, tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].alt);
      e[0] = tbl[i].e0; e[1] = tbl[i].e1; e[2] = tbl[i].e2;
      drive_rows(L, tbl[i].sa, tbl[i].sl, 1'b0);
      check_block($sformatf("vec%0d", i), e, first_cyc, last_cyc, (tbl[i].sa > 0) ? tbl[i].sl : 0);
    end

    // Back-to-back blocks with in_valid held high across the gap.
    fill_const(100, 100, 110, 90, 1'b0);
    drive_rows(L, 0, 0, 1'b1);
    fa = first_cyc; la = last_cyc;
    fill_const(255, 0, 255, 128, 1'b0);
    drive_rows(L, 0, 0, 1'b0);
    fb = first_cyc; lb = last_cyc; wb = ready_waits;
    e[0] = 0; e[1] = 10; e[2] = 10;
    check_block("b2b A", e, fa, la, 0);
    e[0] = 255; e[1] = 0; e[2] = 127;
    check_block("b2b B", e, fb, lb, 0);
    chk("b2b next accept gap", fb - la, 4);
    chk("b2b in_ready low cycles", wb, 3);

    // Reset after 4 rows discards the block.
    fill_const(255, 0, 255, 128, 1'b0);
    drive_rows(4, 0, 0, 1'b0);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("midreset sads", sads_o, 0);
    chk("midreset busy", busy_o, 0);
    chk("midreset in_ready", in_ready_o, 1);
    repeat (10) @(negedge clk);
    chk("midreset no pulse", pq_cyc.size(), 0);
    fill_const(20, 27, 13, 27, 1'b0);
    drive_rows(L, 0, 0, 1'b0);
    e[0] = 7; e[1] = 7; e[2] = 7;
    check_block("post reset", e, first_cyc, last_cyc, 0);

    for (int b = 0; b < 10; b++) begin
      int sa = $urandom_range(0, 7);
      int sl = $urandom_range(0, 4);
      for (int r = 0; r < L; r++)
        for (int p = 0; p < W; p++) begin
          int v = $urandom_range(0, 255);
          int d = $urandom_range(0, 40) - 20;
          int q = v + d;
          if (q < 0) q = 0;
          if (q > 255) q = 255;
          b_orig[r][p]    = 8'(v);
          b_pred[0][r][p] = 8'($urandom_range(0, 255));
          b_pred[1][r][p] = 8'(q);
          b_pred[2][r][p] = (b % 2 == 0) ? 8'(v) : 8'(255 - v);
        end
      e = model();
      drive_rows(L, sa, sl, 1'b0);
      check_block($sformatf("rand%0d", b), e, first_cyc, last_cyc, (sa > 0) ? sl : 0);
    end

    repeat (6) @(negedge clk);
    chk("stray pulses", pq_cyc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
